uart_mem_loader: RTL and testbench

UART_MEM_LOADER -- requirements
Module: uart_mem_loader

---
 rtl/uart_mem_loader.sv | 148 ++++++++++++++
 tb/tb_uart_mem_loader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - serial command loader turning 'W'/'R' byte commands into memory requests.
// Optional LOADER_ACK_EN: writes are acknowledged with a single '.' byte on the transmitter.
module uart_mem_loader #(
    parameter logic [1:0]  ID      = 2'd3,
    parameter logic [26:0] TIMEOUT = 27'd5000000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [7:0]  rs232in_data,
    input  logic        rs232in_attention,
    input  logic        rs232out_busy,
    output logic        rs232out_w,
    output logic [7:0]  rs232out_d,
    input  logic        mem_waitrequest,
    output logic [1:0]  mem_id,
    output logic [29:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_writedatamask,
    input  logic [31:0] mem_readdata,
    input  logic [1:0]  mem_readdataid,
    output logic        active
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WREQ  = 3'd3;
    localparam logic [2:0] S_RREQ  = 3'd4;
    localparam logic [2:0] S_RWAIT = 3'd5;
    localparam logic [2:0] S_TX    = 3'd6;
    localparam logic [2:0] S_ACK   = 3'd7;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

    logic [2:0]  state;
    logic        is_write;
    logic [1:0]  byte_cnt;
    logic [26:0] gap_cnt;
    logic [31:0] tx_word;
    logic        strobe_q;
    logic        tx_slot;

`ifdef LOADER_ACK_EN
    assign tx_slot = (state == S_TX) || (state == S_ACK);
`else
    assign tx_slot = (state == S_TX);
`endif

    // The cycle after a strobe is skipped so the transmitter has time to raise busy.
    assign rs232out_w = !rst && tx_slot && !rs232out_busy && !strobe_q;
    assign rs232out_d = (state == S_ACK) ? 8'h2E : tx_word[31:24];

    assign mem_write         = !rst && (state == S_WREQ);
    assign mem_read          = !rst && (state == S_RREQ);
    assign mem_id            = ID;
    assign mem_writedatamask = 4'hF;
    assign active            = !rst && (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= S_IDLE;
            is_write      <= 1'b0;
            byte_cnt      <= 2'd0;
            gap_cnt       <= 27'd0;
            mem_address   <= 30'd0;
            mem_writedata <= 32'd0;
            tx_word       <= 32'd0;
            strobe_q      <= 1'b0;
        end else begin
            strobe_q <= rs232out_w;
            case (state)
                S_IDLE: begin
                    if (rs232in_attention && (rs232in_data == CMD_W || rs232in_data == CMD_R)) begin
                        is_write <= (rs232in_data == CMD_W);
                        byte_cnt <= 2'd0;
                        gap_cnt  <= 27'd0;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR, S_DATA: begin
                    // Expiry wins over a byte arriving in the same cycle.
                    if (gap_cnt == TIMEOUT) begin
                        gap_cnt <= 27'd0;
                        state   <= S_IDLE;
                    end else if (rs232in_attention) begin
                        gap_cnt  <= 27'd0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (state == S_ADDR) begin
                            mem_address <= {mem_address[21:0], rs232in_data};
                        end else begin
                            mem_writedata <= {mem_writedata[23:0], rs232in_data};
                        end
                        if (byte_cnt == 2'd3) begin
                            gap_cnt <= 27'd0;
                            if (state == S_DATA) begin
                                state <= S_WREQ;
                            end else begin
                                state <= is_write ? S_DATA : S_RREQ;
                            end
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 27'd1;
                    end
                end
                S_WREQ: begin
                    if (!mem_waitrequest) begin
                        state <= S_ACK;
                    end
                end
                S_RREQ: begin
                    if (!mem_waitrequest) begin
                        state <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (mem_readdataid == ID) begin
                        tx_word  <= mem_readdata;
                        byte_cnt <= 2'd0;
                        state    <= S_TX;
                    end
                end
                S_TX: begin
                    if (rs232out_w) begin
                        tx_word  <= {tx_word[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_ACK: begin
`ifdef LOADER_ACK_EN
                    if (rs232out_w) begin
                        state <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - directed self-checking bench for uart_mem_loader.
module tb_uart_mem_loader;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rs232in_data = 8'h00;
    logic        rs232in_attention = 1'b0;
    logic        rs232out_busy = 1'b0;
    logic        rs232out_w;
    logic [7:0]  rs232out_d;
    logic        mem_waitrequest = 1'b0;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [31:0] mem_readdata = 32'h0;
    logic [1:0]  mem_readdataid = 2'd0;
    logic        active;

    int checks = 0;
    int errors = 0;

    int wr_cycles, rd_cycles, busy_viol, b2b_viol, both_viol;
    logic [29:0] last_rd_addr;
    logic        prev_w;
    logic [7:0]  tx_q[$];

    uart_mem_loader #(.ID(2'd3), .TIMEOUT(27'd100)) dut (
        .clock(clock), .rst(rst),
        .rs232in_data(rs232in_data), .rs232in_attention(rs232in_attention),
        .rs232out_busy(rs232out_busy), .rs232out_w(rs232out_w), .rs232out_d(rs232out_d),
        .mem_waitrequest(mem_waitrequest), .mem_id(mem_id), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_writedatamask(mem_writedatamask), .mem_readdata(mem_readdata),
        .mem_readdataid(mem_readdataid), .active(active)
    );

    always #5 clock = ~clock;

    initial begin
        wr_cycles = 0; rd_cycles = 0; busy_viol = 0; b2b_viol = 0; both_viol = 0;
        last_rd_addr = '0; prev_w = 1'b0;
    end

    always @(negedge clock) begin
        if (mem_write) wr_cycles++;
        if (mem_read) begin
            rd_cycles++;
            last_rd_addr = mem_address;
        end
        if (mem_read && mem_write) both_viol++;
        if (rs232out_w) begin
            tx_q.push_back(rs232out_d);
            if (rs232out_busy) busy_viol++;
            if (prev_w) b2b_viol++;
        end
        prev_w = rs232out_w;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon;
        wr_cycles = 0; rd_cycles = 0; busy_viol = 0; b2b_viol = 0;
        tx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rs232in_data = b;
        rs232in_attention = 1'b1;
        tick;
        rs232in_attention = 1'b0;
        tick;
    endtask

    task automatic send_last(input logic [7:0] b);
        rs232in_data = b;
        rs232in_attention = 1'b1;
        tick;
        rs232in_attention = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 300 && tx_q.size() < n; i++) tick;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] tag);
        mem_readdata = d;
        mem_readdataid = tag;
        tick;
        mem_readdataid = 2'd0;
    endtask

    task automatic check_tx_word(input string name, input logic [31:0] exp);
        logic [31:0] got;
        got = 32'h0;
        for (int i = 0; i < tx_q.size(); i++) got = {got[23:0], tx_q[i]};
        checks++;
        if (tx_q.size() != 4 || got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d bytes word %08h, expected 4 bytes %08h", name, tx_q.size(), got, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        checks++;
        if ({mem_read, mem_write, rs232out_w, active} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b, expected 0000", {mem_read, mem_write, rs232out_w, active});
        end
        checks++;
        if (mem_address !== 30'h0 || mem_writedata !== 32'h0 || rs232out_d !== 8'h0) begin
            errors++;
            $display("FAIL reset_regs: addr %h data %h d %h, expected all 0", mem_address, mem_writedata, rs232out_d);
        end
        checks++;
        if (mem_id !== 2'd3 || mem_writedatamask !== 4'hF) begin
            errors++;
            $display("FAIL reset_consts: id %0d mask %h, expected 3 F", mem_id, mem_writedatamask);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: active %b, expected 0", active);
        end
    endtask

    task automatic test_ignore;
        clear_mon();
        send_byte(8'h41); send_byte(8'h00); send_byte(8'h77);
        checks++;
        if (active !== 1'b0 || wr_cycles != 0 || rd_cycles != 0 || tx_q.size() != 0) begin
            errors++;
            $display("FAIL ignore: active %b wr %0d rd %0d tx %0d, expected 0 0 0 0", active, wr_cycles, rd_cycles, tx_q.size());
        end
    endtask

    task automatic test_write;
        clear_mon();
        mem_waitrequest = 1'b0;
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        send_last(8'hEF);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL write_latency: write %b read %b, expected 1 0", mem_write, mem_read);
        end
        checks++;
        if (mem_address !== 30'h100 || mem_writedata !== 32'hDEADBEEF || mem_writedatamask !== 4'hF) begin
            errors++;
            $display("FAIL write_payload: addr %h data %h mask %h, expected 100 DEADBEEF F", mem_address, mem_writedata, mem_writedatamask);
        end
        repeat (6) tick;
        checks++;
        if (wr_cycles != 1 || mem_write !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL write_once: cycles %0d write %b active %b, expected 1 0 0", wr_cycles, mem_write, active);
        end
`ifdef LOADER_ACK_EN
        checks++;
        if (tx_q.size() != 1 || (tx_q.size() == 1 && tx_q[0] !== 8'h2E)) begin
            errors++;
            $display("FAIL write_ack: %0d bytes, expected one 2E", tx_q.size());
        end
`else
        checks++;
        if (tx_q.size() != 0) begin
            errors++;
            $display("FAIL write_silent: %0d bytes, expected 0", tx_q.size());
        end
`endif
    endtask

    task automatic test_read_stall;
        clear_mon();
        mem_waitrequest = 1'b1;
        send_byte(8'h52);
        send_byte(8'hC0); send_byte(8'h00); send_byte(8'h00);
        send_last(8'h10);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_read !== 1'b1 || mem_address !== 30'h10) begin
                errors++;
                $display("FAIL read_stall_%0d: read %b addr %h, expected 1 10", i, mem_read, mem_address);
            end
            tick;
        end
        mem_waitrequest = 1'b0;
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL read_accept: read %b, expected 1", mem_read);
        end
        tick;
        checks++;
        if (mem_read !== 1'b0 || active !== 1'b1 || rd_cycles != 6) begin
            errors++;
            $display("FAIL read_drop: read %b active %b cycles %0d, expected 0 1 6", mem_read, active, rd_cycles);
        end
        tick; tick;
        respond(32'h12345678, 2'd3);
        wait_tx(4);
        check_tx_word("read_tx", 32'h12345678);
        tick; tick;
        checks++;
        if (active !== 1'b0 || b2b_viol != 0) begin
            errors++;
            $display("FAIL read_done: active %b back_to_back %0d, expected 0 0", active, b2b_viol);
        end
    endtask

    task automatic test_tag_filter;
        clear_mon();
        mem_waitrequest = 1'b0;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_last(8'h20);
        tick; tick;
        respond(32'hFFFFFFFF, 2'd1);
        tick;
        respond(32'h0000A5A5, 2'd3);
        wait_tx(4);
        check_tx_word("tag_filter", 32'h0000A5A5);
    endtask

    task automatic test_timeout;
        clear_mon();
        mem_waitrequest = 1'b0;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        repeat (99) tick;
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: active %b, expected 1", active);
        end
        tick;
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL timeout_expire: active %b, expected 0", active);
        end
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_last(8'h04);
        tick; tick;
        respond(32'hCAFEF00D, 2'd3);
        wait_tx(4);
        checks++;
        if (wr_cycles != 0 || rd_cycles != 1 || last_rd_addr !== 30'h4) begin
            errors++;
            $display("FAIL timeout_recover: wr %0d rd %0d addr %h, expected 0 1 4", wr_cycles, rd_cycles, last_rd_addr);
        end
        check_tx_word("timeout_tx", 32'hCAFEF00D);
    endtask

    task automatic test_busy;
        clear_mon();
        mem_waitrequest = 1'b0;
        rs232out_busy = 1'b1;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_last(8'h08);
        tick; tick;
        respond(32'h89ABCDEF, 2'd3);
        repeat (50) tick;
        checks++;
        if (tx_q.size() != 0 || active !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold: %0d bytes active %b, expected 0 1", tx_q.size(), active);
        end
        rs232out_busy = 1'b0;
        wait_tx(4);
        check_tx_word("busy_tx", 32'h89ABCDEF);
        checks++;
        if (busy_viol != 0 || b2b_viol != 0) begin
            errors++;
            $display("FAIL busy_rules: busy_strobes %0d back_to_back %0d, expected 0 0", busy_viol, b2b_viol);
        end
    endtask

    task automatic test_reset_mid;
        clear_mon();
        mem_waitrequest = 1'b1;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_last(8'h0C);
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: read %b, expected 1", mem_read);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        mem_waitrequest = 1'b0;
        checks++;
        if (mem_read !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: read %b active %b, expected 0 0", mem_read, active);
        end
        tick;
        respond(32'h55AA55AA, 2'd3);
        repeat (20) tick;
        checks++;
        if (tx_q.size() != 0 || active !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stale: %0d bytes active %b, expected 0 0", tx_q.size(), active);
        end
        checks++;
        if (both_viol != 0) begin
            errors++;
            $display("FAIL exclusive_strobes: %0d overlaps, expected 0", both_viol);
        end
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_write();
        test_read_stall();
        test_tag_filter();
        test_timeout();
        test_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
